// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of every handshake and data signal around mem_arbiter.
//   icache side : ic_req, ic_addr in; ic_ack, ic_rdata out
//   dcache side : dc_req, dc_we, dc_addr, dc_wdata in; dc_ack, dc_rdata out
//   memory side : mem_raddr, mem_waddr, mem_wdata, mem_we out; mem_rdata in
//   status      : busy out
// The slave modport is the arbiter's view; master is the view of the
// caches/memory surrounding it.
interface mem_arbiter_if #(
    parameter int ADDR_W = 20,
    parameter int LINE_W = 128
);
    logic              ic_req;
    logic [ADDR_W-1:0] ic_addr;
    logic              ic_ack;
    logic [LINE_W-1:0] ic_rdata;

    logic              dc_req;
    logic              dc_we;
    logic [ADDR_W-1:0] dc_addr;
    logic [LINE_W-1:0] dc_wdata;
    logic              dc_ack;
    logic [LINE_W-1:0] dc_rdata;

    logic [ADDR_W-1:0] mem_raddr;
    logic [ADDR_W-1:0] mem_waddr;
    logic [LINE_W-1:0] mem_wdata;
    logic              mem_we;
    logic [LINE_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  ic_req, ic_addr,
        input  dc_req, dc_we, dc_addr, dc_wdata,
        input  mem_rdata,
        output ic_ack, ic_rdata,
        output dc_ack, dc_rdata,
        output mem_raddr, mem_waddr, mem_wdata, mem_we,
        output busy
    );

    modport master (
        output ic_req, ic_addr,
        output dc_req, dc_we, dc_addr, dc_wdata,
        output mem_rdata,
        input  ic_ack, ic_rdata,
        input  dc_ack, dc_rdata,
        input  mem_raddr, mem_waddr, mem_wdata, mem_we,
        input  busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single 128-bit line port of ram_memory between the
// icache miss path and the dcache miss/writeback path. Requests are granted
// round-robin, the granted address/data are held for MEM_LAT cycles, read
// lines are returned to the winner and each writeback fires one write strobe.
// Ports:
//   clk   in  rising-edge clock
//   reset in  asynchronous, active-low reset
//   bus   mem_arbiter_if.slave: cache request/ack/rdata, memory address,
//         write data, write strobe, read data return, busy status
// MEM_LAT legal range is 1..15.
module mem_arbiter #(
    parameter int ADDR_W  = 20,
    parameter int LINE_W  = 128,
    parameter int MEM_LAT = 4
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_t     state;
    logic       last_dc;
    logic       gnt_dc;
    logic       lat_we;
    logic [3:0] cnt;
    logic       pick_dc;

    // On a tie the requester that did not win the previous grant goes next.
    always_comb begin
        pick_dc = 1'b0;
        if (bus.dc_req && bus.ic_req) begin
            pick_dc = !last_dc;
        end else begin
            pick_dc = bus.dc_req;
        end
    end

    // Acks and the write strobe are single-cycle pulses, so they default low
    // every cycle. mem_we is raised on the edge entering the final ACCESS
    // cycle (cnt==0), which for MEM_LAT=1 is the grant edge itself.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            last_dc       <= 1'b1;
            gnt_dc        <= 1'b0;
            lat_we        <= 1'b0;
            cnt           <= 4'd0;
            bus.ic_ack    <= 1'b0;
            bus.ic_rdata  <= '0;
            bus.dc_ack    <= 1'b0;
            bus.dc_rdata  <= '0;
            bus.mem_raddr <= '0;
            bus.mem_waddr <= '0;
            bus.mem_wdata <= '0;
            bus.mem_we    <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            bus.ic_ack <= 1'b0;
            bus.dc_ack <= 1'b0;
            bus.mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.ic_req || bus.dc_req) begin
                        gnt_dc        <= pick_dc;
                        last_dc       <= pick_dc;
                        lat_we        <= pick_dc && bus.dc_we;
                        bus.mem_raddr <= pick_dc ? bus.dc_addr : bus.ic_addr;
                        bus.mem_waddr <= pick_dc ? bus.dc_addr : bus.ic_addr;
                        bus.mem_wdata <= pick_dc ? bus.dc_wdata : '0;
                        bus.mem_we    <= (MEM_LAT == 1) && pick_dc && bus.dc_we;
                        cnt           <= CNT_INIT;
                        bus.busy      <= 1'b1;
                        state         <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        if (!lat_we) begin
                            if (gnt_dc) begin
                                bus.dc_rdata <= bus.mem_rdata;
                            end else begin
                                bus.ic_rdata <= bus.mem_rdata;
                            end
                        end
                        bus.ic_ack <= !gnt_dc;
                        bus.dc_ack <= gnt_dc;
                        state      <= RESP;
                    end else begin
                        cnt        <= cnt - 4'd1;
                        bus.mem_we <= lat_we && (cnt == 4'd1);
                    end
                end
                RESP: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter.
// Main instance (MEM_LAT=4) is driven by two request agents fed from queues
// and watched every cycle against a transaction-level model: an arbiter that
// is either free or owns one transaction whose ack cycle is grant+MEM_LAT+1,
// plus a reference memory holding the architecturally expected line values.
// A second instance (MEM_LAT=1) covers the shortest latency with directed
// transactions.
module tb_mem_arbiter;
    localparam int ADDR_W = 20;
    localparam int LINE_W = 128;
    localparam int LAT    = 4;
    localparam int RAM_N  = 2048;

    typedef struct {
        bit           we;
        logic [19:0]  addr;
        logic [127:0] wdata;
        int           delay;
    } txn_t;

    logic clk    = 1'b0;
    logic reset  = 1'b0;
    logic reset1 = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus  ();
    mem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus1 ();

    mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .MEM_LAT(LAT)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .MEM_LAT(1)) u_dut1 (
        .clk   (clk),
        .reset (reset1),
        .bus   (bus1)
    );

    // Simple ram_memory stand-ins: combinational read, write on the strobe.
    logic [127:0] ram  [RAM_N];
    logic [127:0] ram1 [RAM_N];
    assign bus.mem_rdata  = ram[bus.mem_raddr[10:0]];
    assign bus1.mem_rdata = ram1[bus1.mem_raddr[10:0]];
    always @(posedge clk) if (bus.mem_we) ram[bus.mem_waddr[10:0]] = bus.mem_wdata;
    always @(posedge clk) if (bus1.mem_we) ram1[bus1.mem_waddr[10:0]] = bus1.mem_wdata;

    function automatic logic [127:0] line_init(input logic [19:0] a);
        logic [31:0] x;
        x = {21'd0, a[10:0]};
        return {x ^ 32'hDEADBEEF, ~x, x * 32'd2654435761, x + 32'h12345678};
    endfunction

    initial begin
        for (int i = 0; i < RAM_N; i++) begin
            ram[i]  = line_init(20'(i));
            ram1[i] = line_init(20'(i));
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s (cycle %0d): got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // Reference memory: expected line contents after completed writebacks.
    logic [127:0] ref_mem [bit [19:0]];
    function automatic logic [127:0] ref_read(input logic [19:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return line_init(a);
    endfunction

    // Request agents.
    txn_t ic_q[$];
    txn_t dc_q[$];
    txn_t ic_cur, dc_cur;
    bit   ic_active = 0, dc_active = 0;
    int   ic_hold = 0, dc_hold = 0;
    bit   ic_ack_seen = 0, dc_ack_seen = 0;
    int   ic_present_cyc = 0;

    // Transaction-level arbiter model.
    bit           m_busy = 0;
    bit           m_last_dc = 1;
    bit           m_dc = 0;
    bit           m_we = 0;
    logic [19:0]  m_addr = '0;
    logic [127:0] m_wdata = '0;
    int           m_c0 = 0;
    int           m_ack_c = 0;
    int           m_next_free = 0;

    // Observations of the DUT used by directed checks.
    int           ack_log[$];
    int           we_seen_cnt = 0;
    int           dc_ack_cnt = 0;
    int           last_ic_ack_cyc = 0;
    logic [19:0]  we_addr_seen = '0;
    logic [127:0] last_ic_rdata = '0;
    logic [127:0] last_dc_rdata = '0;

    task automatic applyStimulus(input bit to_dc, input bit we, input logic [19:0] addr,
                                 input logic [127:0] wdata, input int delay);
        txn_t t;
        t.we    = to_dc ? we : 1'b0;
        t.addr  = addr;
        t.wdata = wdata;
        t.delay = delay;
        if (to_dc) begin
            if (!dc_active && dc_q.size() == 0) dc_hold = cyc + delay;
            dc_q.push_back(t);
        end else begin
            if (!ic_active && ic_q.size() == 0) ic_hold = cyc + delay;
            ic_q.push_back(t);
        end
    endtask

    task automatic monitorCycle();
        bit exp_ic_ack, exp_dc_ack, exp_we, exp_busy, win_dc;
        if (!reset) begin
            m_busy      = 0;
            m_last_dc   = 1;
            m_next_free = cyc + 1;
            checkOutput("rst_ic_rdata", bus.ic_rdata, '0);
            checkOutput("rst_dc_rdata", bus.dc_rdata, '0);
            checkOutput("rst_mem_addr", 128'({bus.mem_raddr, bus.mem_waddr}), '0);
            checkOutput("rst_mem_wdata", bus.mem_wdata, '0);
        end
        exp_ic_ack = m_busy && (cyc == m_ack_c) && !m_dc;
        exp_dc_ack = m_busy && (cyc == m_ack_c) && m_dc;
        exp_we     = m_busy && m_we && (cyc == m_ack_c - 1);
        exp_busy   = m_busy && (cyc > m_c0);
        checkOutput("ic_ack", 128'(bus.ic_ack), 128'(exp_ic_ack));
        checkOutput("dc_ack", 128'(bus.dc_ack), 128'(exp_dc_ack));
        checkOutput("ack_excl", 128'(bus.ic_ack & bus.dc_ack), '0);
        checkOutput("mem_we", 128'(bus.mem_we), 128'(exp_we));
        checkOutput("busy", 128'(bus.busy), 128'(exp_busy));
        if (m_busy && cyc > m_c0 && cyc < m_ack_c)
            checkOutput("mem_raddr", 128'(bus.mem_raddr), 128'(m_addr));
        if (exp_we) begin
            checkOutput("mem_waddr", 128'(bus.mem_waddr), 128'(m_addr));
            checkOutput("mem_wdata", bus.mem_wdata, m_wdata);
        end

        if (bus.mem_we) begin
            we_seen_cnt++;
            we_addr_seen = bus.mem_waddr;
        end
        if (bus.ic_ack) begin
            ack_log.push_back(0);
            last_ic_ack_cyc = cyc;
            last_ic_rdata   = bus.ic_rdata;
        end
        if (bus.dc_ack) begin
            ack_log.push_back(1);
            dc_ack_cnt++;
            last_dc_rdata = bus.dc_rdata;
        end
        ic_ack_seen = bus.ic_ack;
        dc_ack_seen = bus.dc_ack;

        if (m_busy && cyc == m_ack_c) begin
            if (m_we) ref_mem[m_addr] = m_wdata;
            else if (m_dc) checkOutput("dc_rdata", bus.dc_rdata, ref_read(m_addr));
            else checkOutput("ic_rdata", bus.ic_rdata, ref_read(m_addr));
            m_busy      = 0;
            m_next_free = cyc + 1;
        end

        if (reset && !m_busy && cyc >= m_next_free && (bus.ic_req || bus.dc_req)) begin
            if (bus.ic_req && bus.dc_req) win_dc = !m_last_dc;
            else win_dc = bus.dc_req;
            m_busy    = 1;
            m_last_dc = win_dc;
            m_dc      = win_dc;
            m_we      = win_dc && dc_cur.we;
            m_addr    = win_dc ? dc_cur.addr : ic_cur.addr;
            m_wdata   = dc_cur.wdata;
            m_c0      = cyc;
            m_ack_c   = cyc + LAT + 1;
        end
    endtask

    task automatic agentStep();
        if (ic_ack_seen) begin
            ic_active  = 0;
            bus.ic_req = 1'b0;
            ic_hold    = cyc + ((ic_q.size() > 0) ? ic_q[0].delay : 0);
        end
        if (!ic_active && ic_q.size() > 0 && cyc >= ic_hold) begin
            ic_cur         = ic_q.pop_front();
            bus.ic_addr    = ic_cur.addr;
            bus.ic_req     = 1'b1;
            ic_active      = 1;
            ic_present_cyc = cyc;
        end
        if (dc_ack_seen) begin
            dc_active  = 0;
            bus.dc_req = 1'b0;
            dc_hold    = cyc + ((dc_q.size() > 0) ? dc_q[0].delay : 0);
        end
        if (!dc_active && dc_q.size() > 0 && cyc >= dc_hold) begin
            dc_cur       = dc_q.pop_front();
            bus.dc_addr  = dc_cur.addr;
            bus.dc_we    = dc_cur.we;
            bus.dc_wdata = dc_cur.wdata;
            bus.dc_req   = 1'b1;
            dc_active    = 1;
        end
        ic_ack_seen = 0;
        dc_ack_seen = 0;
    endtask

    task automatic step();
        @(negedge clk);
        monitorCycle();
        @(posedge clk);
        cyc++;
        #1;
        agentStep();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((ic_q.size() > 0 || dc_q.size() > 0 || ic_active || dc_active || m_busy) && n < budget) begin
            step();
            n++;
        end
        checkOutput("drain_done",
                    128'((ic_q.size() + dc_q.size() + int'(ic_active) + int'(dc_active) + int'(m_busy)) == 0),
                    128'(1));
    endtask

    task automatic doReset(input int n);
        reset = 1'b0;
        repeat (n) step();
        reset = 1'b1;
    endtask

    task automatic lat1Txn(input bit to_dc, input bit we, input logic [19:0] addr, input logic [127:0] wdata,
                           output int ack_at, output int we_cnt, output int we_at, output logic [127:0] rdata);
        bus1.ic_req   = !to_dc;
        bus1.dc_req   = to_dc;
        bus1.ic_addr  = addr;
        bus1.dc_addr  = addr;
        bus1.dc_we    = to_dc && we;
        bus1.dc_wdata = wdata;
        ack_at = 0;
        we_cnt = 0;
        we_at  = 0;
        rdata  = '0;
        @(posedge clk);
        for (int k = 1; k <= 8 && ack_at == 0; k++) begin
            @(negedge clk);
            if (bus1.mem_we) begin
                we_cnt++;
                we_at = k;
            end
            if (bus1.ic_ack || bus1.dc_ack) begin
                ack_at = k;
                rdata  = to_dc ? bus1.dc_rdata : bus1.ic_rdata;
            end
        end
        @(posedge clk);
        #1;
        bus1.ic_req = 1'b0;
        bus1.dc_req = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [127:0] t5_data, t6_data, rd;
        int n, ack_at, we_cnt, we_at;

        bus.ic_req = 1'b0;  bus.ic_addr = '0;
        bus.dc_req = 1'b0;  bus.dc_we = 1'b0;  bus.dc_addr = '0;  bus.dc_wdata = '0;
        bus1.ic_req = 1'b0; bus1.ic_addr = '0;
        bus1.dc_req = 1'b0; bus1.dc_we = 1'b0; bus1.dc_addr = '0; bus1.dc_wdata = '0;

        $display("[TB] reset state");
        repeat (3) step();
        reset = 1'b1;

        $display("[TB] single icache read");
        we_seen_cnt = 0;
        applyStimulus(0, 0, 20'h00010, '0, 0);
        drain(200);
        checkOutput("t1_latency", 128'(last_ic_ack_cyc - ic_present_cyc), 128'(LAT + 1));
        checkOutput("t1_no_we", 128'(we_seen_cnt), '0);
        checkOutput("t1_rdata", last_ic_rdata, line_init(20'h00010));

        $display("[TB] dcache writeback and readback");
        we_seen_cnt = 0;
        applyStimulus(1, 1, 20'h00400, {16{8'hA5}}, 0);
        applyStimulus(1, 0, 20'h00400, '0, 0);
        drain(200);
        checkOutput("t2_we_count", 128'(we_seen_cnt), 128'(1));
        checkOutput("t2_waddr", 128'(we_addr_seen), 128'(20'h00400));
        checkOutput("t2_readback", last_dc_rdata, {16{8'hA5}});

        $display("[TB] simultaneous requests after reset");
        doReset(2);
        ack_log.delete();
        applyStimulus(0, 0, 20'h00020, '0, 0);
        applyStimulus(1, 0, 20'h00030, '0, 0);
        drain(200);
        checkOutput("t3_acks", 128'(ack_log.size()), 128'(2));
        checkOutput("t3_first", 128'((ack_log.size() > 0) ? ack_log[0] : 9), '0);
        checkOutput("t3_second", 128'((ack_log.size() > 1) ? ack_log[1] : 9), 128'(1));

        $display("[TB] continuous requests alternate");
        ack_log.delete();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 20'(64 + i * 16), '0, 0);
            applyStimulus(1, 0, 20'(128 + i * 16), '0, 0);
        end
        drain(300);
        checkOutput("t4_acks", 128'(ack_log.size()), 128'(6));
        for (int i = 0; i < ack_log.size(); i++)
            checkOutput($sformatf("t4_order%0d", i), 128'(ack_log[i]), 128'(i % 2));

        $display("[TB] reset during writeback");
        t5_data = {$urandom, $urandom, $urandom, $urandom};
        we_seen_cnt = 0;
        dc_ack_cnt  = 0;
        applyStimulus(1, 1, 20'h00123, t5_data, 0);
        n = 0;
        while (!(m_busy && m_dc && m_we && cyc > m_c0) && n < 50) begin
            step();
            n++;
        end
        checkOutput("t5_in_access", 128'(bus.busy), 128'(1));
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        checkOutput("t5_aborted_we", 128'(we_seen_cnt), '0);
        checkOutput("t5_aborted_ack", 128'(dc_ack_cnt), '0);
        drain(200);
        checkOutput("t5_we_count", 128'(we_seen_cnt), 128'(1));
        checkOutput("t5_ack_count", 128'(dc_ack_cnt), 128'(1));
        applyStimulus(1, 0, 20'h00123, '0, 0);
        drain(200);
        checkOutput("t5_readback", last_dc_rdata, t5_data);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 40; i++) begin
            bit side, we;
            side = 1'($urandom_range(0, 1));
            we   = side & 1'($urandom_range(0, 1));
            applyStimulus(side, we, 20'($urandom_range(0, 63) * 32),
                          {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 3));
        end
        drain(3000);

        $display("[TB] MEM_LAT=1 instance");
        reset1  = 1'b1;
        t6_data = {$urandom, $urandom, $urandom, $urandom};
        lat1Txn(0, 0, 20'h02000, '0, ack_at, we_cnt, we_at, rd);
        checkOutput("t6_ic_ack_cycle", 128'(ack_at), 128'(2));
        checkOutput("t6_ic_rdata", rd, line_init(20'h02000));
        checkOutput("t6_ic_no_we", 128'(we_cnt), '0);
        lat1Txn(1, 1, 20'h00055, t6_data, ack_at, we_cnt, we_at, rd);
        checkOutput("t6_wr_ack_cycle", 128'(ack_at), 128'(2));
        checkOutput("t6_wr_we_count", 128'(we_cnt), 128'(1));
        checkOutput("t6_wr_we_cycle", 128'(we_at), 128'(1));
        lat1Txn(1, 0, 20'h00055, '0, ack_at, we_cnt, we_at, rd);
        checkOutput("t6_rd_ack_cycle", 128'(ack_at), 128'(2));
        checkOutput("t6_rd_data", rd, t6_data);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
